// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter and sequencer sharing one MAR + RAM pair between fetch, load/store and loader.
// Each transaction loads the MAR, optionally waits, accesses the RAM once, then acknowledges the winner.
module mem_access_arbiter #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int MEM_WAIT      = 0
) (
  input  logic                       i_CLOCK,
  input  logic                       i_CLEAR_N,
  input  logic [2:0]                 i_REQ,
  input  logic [2:0]                 i_WE,
  input  logic [3*ADDRESS_WIDTH-1:0] i_ADDR,
  input  logic [3*DATA_WIDTH-1:0]    i_WDATA,
  output logic [2:0]                 o_GNT,
  output logic [2:0]                 o_ACK,
  output logic [DATA_WIDTH-1:0]      o_RDATA,
  output logic                       o_ERROR,
  output logic [ADDRESS_WIDTH-1:0]   o_MAR_BUS,
  output logic                       o_MAR_READ_BUS,
  input  logic [ADDRESS_WIDTH-1:0]   i_MAR_DATA,
  output logic                       o_RAM_WE,
  output logic [DATA_WIDTH-1:0]      o_RAM_WDATA,
  input  logic [DATA_WIDTH-1:0]      i_RAM_RDATA,
  output logic [2:0]                 o_STATE
);

  // Handshake: a requester holds i_REQ[k] and its WE/ADDR/WDATA until o_ACK[k] pulses for one cycle;
  // o_GNT[k] marks ownership from arbitration to the end of the ACK cycle, and a dropped REQ never aborts.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ACK    = 3'd4
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'((MEM_WAIT > 0) ? (MEM_WAIT - 1) : 0);

  state_t                   state;
  logic [1:0]               rr_ptr;
  logic [1:0]               winner;
  logic [1:0]               cand;
  logic                     win_valid;
  logic                     lat_we;
  logic [ADDRESS_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0]    lat_wdata;
  logic [3:0]               wait_cnt;
  logic                     go_access;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Scan starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    cand      = rr_ptr;
    winner    = 2'd0;
    win_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cand = next_idx(cand);
      if (!win_valid && i_REQ[cand]) begin
        winner    = cand;
        win_valid = 1'b1;
      end
    end
  end

  assign go_access = ((state == ST_LOAD) && (MEM_WAIT == 0)) ||
                     ((state == ST_WAIT) && (wait_cnt == 4'd0));
  assign o_STATE   = state;

  always_ff @(posedge i_CLOCK or negedge i_CLEAR_N) begin
    if (!i_CLEAR_N) begin
      state          <= ST_IDLE;
      rr_ptr         <= 2'd2;
      lat_we         <= 1'b0;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      wait_cnt       <= 4'd0;
      o_GNT          <= 3'b000;
      o_ACK          <= 3'b000;
      o_RDATA        <= '0;
      o_ERROR        <= 1'b0;
      o_MAR_BUS      <= '0;
      o_MAR_READ_BUS <= 1'b0;
      o_RAM_WE       <= 1'b0;
      o_RAM_WDATA    <= '0;
    end else begin
      o_ACK          <= 3'b000;
      o_ERROR        <= 1'b0;
      o_MAR_READ_BUS <= 1'b0;
      o_RAM_WE       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            o_GNT          <= 3'b001 << winner;
            rr_ptr         <= winner;
            lat_we         <= i_WE[winner];
            lat_addr       <= i_ADDR[int'(winner)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            lat_wdata      <= i_WDATA[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            o_MAR_BUS      <= i_ADDR[int'(winner)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            o_MAR_READ_BUS <= 1'b1;
            state          <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (!go_access) begin
            wait_cnt <= WAIT_INIT;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!go_access) wait_cnt <= wait_cnt - 4'd1;
        end
        ST_ACCESS: begin
          // The MAR has held the address since LOAD, so its readback must match now.
          if (!lat_we) o_RDATA <= i_RAM_RDATA;
          o_ERROR <= (i_MAR_DATA != lat_addr);
          o_ACK   <= o_GNT;
          state   <= ST_ACK;
        end
        ST_ACK: begin
          o_GNT <= 3'b000;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (go_access) begin
        o_RAM_WE <= lat_we;
        if (lat_we) o_RAM_WDATA <= lat_wdata;
        state <= ST_ACCESS;
      end
    end
  end

endmodule
